// File: rtl/ctr_pkg.sv
// Shared definitions for the counter family: count modes and the decoded per-edge operation.
package ctr_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_UP,
    OP_DN
  } ctr_op_e;

endpackage

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with programmable terminal value, wrap/saturate
// mode, synchronous clear/load, a one-cycle limit pulse and a sticky overflow flag.
module mod_updown_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MODE      = MODE_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] max_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap_p,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   ONE   = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] ZERO  = '0;

  ctr_op_e          op;
  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH:0]   cnt_dec;
  logic [WIDTH-1:0] cnt_nxt;
  logic             lim;
  logic             ovf_nxt;

  always_comb begin
    op = OP_HOLD;
    if (clr)       op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = up_dn ? OP_UP : OP_DN;
  end

  // Extra bit: carry out on increment, borrow (count==0) on decrement.
  assign cnt_inc = {1'b0, count} + ONE;
  assign cnt_dec = {1'b0, count} - ONE;

  always_comb begin
    cnt_nxt = count;
    lim     = 1'b0;
    unique case (op)
      OP_HOLD: cnt_nxt = count;
      OP_CLR:  cnt_nxt = RST_V;
      OP_LOAD: cnt_nxt = (load_val > max_val) ? max_val : load_val;
      OP_UP: begin
        // count above a lowered max_val is treated as hitting the top limit
        if ((count >= max_val) || cnt_inc[WIDTH]) begin
          lim     = 1'b1;
          cnt_nxt = (MODE == MODE_SAT) ? max_val : ZERO;
        end else begin
          cnt_nxt = cnt_inc[WIDTH-1:0];
        end
      end
      OP_DN: begin
        if (count > max_val) begin
          cnt_nxt = max_val;
        end else if (cnt_dec[WIDTH]) begin
          lim     = 1'b1;
          cnt_nxt = (MODE == MODE_SAT) ? ZERO : max_val;
        end else begin
          cnt_nxt = cnt_dec[WIDTH-1:0];
        end
      end
      default: cnt_nxt = count;
    endcase
  end

  // A limit event on the same edge as ovf_clr keeps the flag set.
  assign ovf_nxt = lim | (ovf & ~ovf_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= RST_V;
      wrap_p <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      count  <= cnt_nxt;
      wrap_p <= lim;
      ovf    <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench: WRAP and SAT instances share stimulus; an integer reference model predicts both.
module tb_mod_updown_counter;
  import ctr_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clr = 1'b0, en = 1'b0, load = 1'b0, up_dn = 1'b1, ovf_clr = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] max_val = 4'd9;
  logic [W-1:0] count_w, count_s;
  logic         wrap_w, wrap_s, ovf_w, ovf_s;

  int n_chk = 0;
  int n_err = 0;

  // reference state: index 0 = wrap instance, 1 = saturate instance
  int m_cnt [2];
  int m_wrp [2];
  int m_ovf [2];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(W), .MODE(MODE_WRAP), .RESET_VAL(0)) dut_w (
    .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .max_val(max_val), .ovf_clr(ovf_clr),
    .count(count_w), .wrap_p(wrap_w), .ovf(ovf_w));

  mod_updown_counter #(.WIDTH(W), .MODE(MODE_SAT), .RESET_VAL(0)) dut_s (
    .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .max_val(max_val), .ovf_clr(ovf_clr),
    .count(count_s), .wrap_p(wrap_s), .ovf(ovf_s));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_wrp[k] = 0;
      m_ovf[k] = 0;
    end
  endtask

  task automatic model_step();
    int mx, lv, c;
    bit hit, sat;
    mx = int'(max_val);
    lv = int'(load_val);
    for (int k = 0; k < 2; k++) begin
      sat = (k == 1);
      c   = m_cnt[k];
      hit = 1'b0;
      if (clr)       c = 0;
      else if (load) c = (lv < mx) ? lv : mx;
      else if (en) begin
        if (up_dn) begin
          if (c < mx) c = c + 1;
          else begin hit = 1'b1; c = sat ? mx : 0; end
        end else begin
          if (c > mx)       c = mx;
          else if (c == 0)  begin hit = 1'b1; c = sat ? 0 : mx; end
          else              c = c - 1;
        end
      end
      m_cnt[k] = c;
      m_wrp[k] = hit ? 1 : 0;
      m_ovf[k] = hit ? 1 : (ovf_clr ? 0 : m_ovf[k]);
    end
  endtask

  task automatic compare_all();
    chk("count_wrap", int'(count_w), m_cnt[0]);
    chk("wrap_p_wrap", int'(wrap_w), m_wrp[0]);
    chk("ovf_wrap", int'(ovf_w), m_ovf[0]);
    chk("count_sat", int'(count_s), m_cnt[1]);
    chk("wrap_p_sat", int'(wrap_s), m_wrp[1]);
    chk("ovf_sat", int'(ovf_s), m_ovf[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    clr = 0; load = 0; en = 0; ovf_clr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sat_exp_cnt [3];
    int sat_exp_wrp [3];
    sat_exp_cnt = '{9, 9, 9};
    sat_exp_wrp = '{0, 1, 1};

    model_reset();
    #12;
    compare_all();
    chk("reset_count", int'(count_w), 0);
    reset_n = 1'b1;
    #1;

    // up wrap over 0..9
    max_val = 4'd9; en = 1; up_dn = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("upwrap_seq", int'(count_w), (i == 10) ? 0 : i);
    end
    chk("upwrap_pulse", int'(wrap_w), 1);
    chk("upwrap_ovf", int'(ovf_w), 1);
    en = 0;
    tick();
    chk("upwrap_pulse_end", int'(wrap_w), 0);
    chk("upwrap_ovf_sticky", int'(ovf_w), 1);

    // down wrap from 0
    load = 1; load_val = 4'd0; tick();
    load = 0; en = 1; up_dn = 0; tick();
    chk("dnwrap_count", int'(count_w), 9);
    chk("dnwrap_pulse", int'(wrap_w), 1);

    // saturate from 8
    idle_inputs(); load = 1; load_val = 4'd8; tick();
    load = 0; en = 1; up_dn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_count", int'(count_s), sat_exp_cnt[i]);
      chk("sat_pulse", int'(wrap_s), sat_exp_wrp[i]);
    end
    chk("sat_ovf", int'(ovf_s), 1);

    // priority and clamp
    clr = 1; load = 1; en = 1; load_val = 4'd5; tick();
    chk("prio_clr", int'(count_w), 0);
    clr = 0; en = 0; load_val = 4'd15; tick();
    chk("load_clamp", int'(count_w), 9);
    chk("load_no_pulse", int'(wrap_w), 0);

    // run-time max_val drop below count
    load_val = 4'd7; tick();
    load = 0; max_val = 4'd4; en = 1; up_dn = 1; tick();
    chk("drop_up_count", int'(count_w), 0);
    chk("drop_up_pulse", int'(wrap_w), 1);
    en = 0; load = 1; max_val = 4'd9; load_val = 4'd7; tick();
    load = 0; max_val = 4'd4; en = 1; up_dn = 0; tick();
    chk("drop_dn_count", int'(count_w), 4);
    chk("drop_dn_pulse", int'(wrap_w), 0);

    // async reset between edges, then ovf_clr colliding with a limit event
    max_val = 4'd9; up_dn = 1; tick(); tick();
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_count", int'(count_w), 0);
    chk("rst_async_ovf", int'(ovf_w), 0);
    compare_all();
    max_val = 4'd0; en = 1; ovf_clr = 1;
    #1;
    reset_n = 1'b1;
    tick();
    chk("ovf_set_wins", int'(ovf_w), 1);
    chk("max0_pulse", int'(wrap_w), 1);
    chk("max0_count", int'(count_w), 0);
    ovf_clr = 1; en = 0; tick();
    chk("ovf_cleared", int'(ovf_w), 0);

    // randomized traffic
    max_val = 4'd9;
    for (int i = 0; i < 600; i++) begin
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = W'($urandom_range(0, 1)) != 0;
      ovf_clr  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) max_val = W'($urandom_range(0, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
